// File: rtl/spi_reg_slave_if.sv
// Bus bundle for spi_reg_slave: the SPI pins plus the register-side read/write port.
// The slave modport is the register port; the master modport is whoever drives the SPI pins and consumes the strobes.
interface spi_reg_slave_if #(
    parameter int DW   = 8,
    parameter int NREG = 4
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic               sclk;
    logic               cs;
    logic               mosi;
    logic               miso;
    logic [NREG*DW-1:0] rd_data;
    logic               rd_stb;
    logic [AW-1:0]      rd_idx;
    logic               wr_stb;
    logic [AW-1:0]      wr_idx;
    logic [DW-1:0]      wr_data;
    logic               busy;

    modport slave (
        input  sclk, cs, mosi, rd_data,
        output miso, rd_stb, rd_idx, wr_stb, wr_idx, wr_data, busy
    );

    modport master (
        output sclk, cs, mosi, rd_data,
        input  miso, rd_stb, rd_idx, wr_stb, wr_idx, wr_data, busy
    );
endinterface

// File: rtl/spi_reg_slave.sv
// Oversampling SPI (mode 0, MSB first) slave serving bursts of DW-bit words over
// NREG consecutive addresses starting at BASE_ADR, with one-cycle read/write strobes.
module spi_reg_slave #(
    parameter int DW       = 8,
    parameter int NREG     = 4,
    parameter int BASE_ADR = 1
) (
    input  logic              clk240,
    input  logic              rst,
    spi_reg_slave_if.slave    bus
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        SKIP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    sclk_sync_q, sclk_sync_d;
    logic [2:0]    cs_sync_q, cs_sync_d;
    logic [2:0]    mosi_sync_q, mosi_sync_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] shift_q, shift_d;
    logic          miso_q, miso_d;
    logic          rd_stb_q, rd_stb_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic          wr_stb_q, wr_stb_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          busy_q, busy_d;

    logic          sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit;
    logic [7:0]    cmd_next;
    logic          cmd_hit;
    logic [AW-1:0] start_idx, idx_next, load_idx;
    logic [DW-1:0] load_word;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign mosi_bit  = mosi_sync_q[2];

    assign cmd_next  = {cmd_q[6:0], mosi_bit};
    assign cmd_hit   = ({1'b0, cmd_next[6:0]} >= 8'(BASE_ADR)) &&
                       ({1'b0, cmd_next[6:0]} < 8'(BASE_ADR + NREG));
    assign start_idx = AW'(cmd_next[6:0] - 7'(BASE_ADR));
    assign idx_next  = (idx_q == AW'(NREG - 1)) ? {AW{1'b0}} : idx_q + AW'(1);
    assign load_idx  = (state_q == ADDR) ? start_idx : idx_next;
    assign load_word = bus.rd_data[load_idx*DW +: DW];

    // Next-state and output computation; cs-rise overrides any sclk event in the same cycle.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], bus.sclk};
        cs_sync_d   = {cs_sync_q[1:0], bus.cs};
        mosi_sync_d = {mosi_sync_q[1:0], bus.mosi};
        state_d     = state_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rd_stb_d    = 1'b0;
        rd_idx_d    = rd_idx_q;
        wr_stb_d    = 1'b0;
        wr_idx_d    = wr_idx_q;
        wr_data_d   = wr_data_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = ADDR;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end
                ADDR: begin
                    if (sclk_rise && (cnt_q == CW'(7))) begin
                        cmd_d = cmd_next;
                        cnt_d = {CW{1'b0}};
                        if (!cmd_hit) begin
                            state_d = SKIP;
                        end else if (cmd_next[7]) begin
                            state_d = DATA;
                            idx_d   = start_idx;
                            shift_d = {DW{1'b0}};
                        end else begin
                            state_d  = DATA;
                            idx_d    = start_idx;
                            shift_d  = load_word;
                            rd_stb_d = 1'b1;
                            rd_idx_d = start_idx;
                        end
                    end else if (sclk_rise) begin
                        cmd_d = cmd_next;
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        state_d = ADDR;
                    end
                end
                DATA: begin
                    if (cmd_q[7] && sclk_rise) begin
                        shift_d = {shift_q[DW-2:0], mosi_bit};
                        if (cnt_q == CW'(DW - 1)) begin
                            cnt_d     = {CW{1'b0}};
                            wr_stb_d  = 1'b1;
                            wr_idx_d  = idx_q;
                            wr_data_d = {shift_q[DW-2:0], mosi_bit};
                            idx_d     = idx_next;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (!cmd_q[7] && sclk_rise) begin
                        if (cnt_q == CW'(DW - 1)) begin
                            cnt_d    = {CW{1'b0}};
                            idx_d    = idx_next;
                            shift_d  = load_word;
                            rd_stb_d = 1'b1;
                            rd_idx_d = idx_next;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (!cmd_q[7] && sclk_fall && (cnt_q != {CW{1'b0}})) begin
                        // The fall right after a load ends the bit just sampled, so the fresh MSB stays put.
                        shift_d = {shift_q[DW-2:0], 1'b1};
                    end else begin
                        state_d = DATA;
                    end
                end
                SKIP: begin
                    state_d = SKIP;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        miso_d = ((state_d == DATA) && !cmd_d[7]) ? shift_d[DW-1] : 1'b1;
        busy_d = (state_d == ADDR) || (state_d == DATA);
    end

    // State and output registers with synchronous reset; cs sync resets low so a held-low cs is not a new frame.
    always_ff @(posedge clk240) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b000;
            mosi_sync_q <= 3'b000;
            cmd_q       <= 8'h00;
            cnt_q       <= {CW{1'b0}};
            idx_q       <= {AW{1'b0}};
            shift_q     <= {DW{1'b0}};
            miso_q      <= 1'b1;
            rd_stb_q    <= 1'b0;
            rd_idx_q    <= {AW{1'b0}};
            wr_stb_q    <= 1'b0;
            wr_idx_q    <= {AW{1'b0}};
            wr_data_q   <= {DW{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            miso_q      <= miso_d;
            rd_stb_q    <= rd_stb_d;
            rd_idx_q    <= rd_idx_d;
            wr_stb_q    <= wr_stb_d;
            wr_idx_q    <= wr_idx_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.miso    = miso_q;
    assign bus.rd_stb  = rd_stb_q;
    assign bus.rd_idx  = rd_idx_q;
    assign bus.wr_stb  = wr_stb_q;
    assign bus.wr_idx  = wr_idx_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_spi_reg_slave.sv
// Randomised bench for spi_reg_slave: two instances (8-bit at 0x01..0x04, 32-bit at 0x20..0x23)
// share one SPI bus and are checked against a word-level model of each transaction.
module tb_spi_reg_slave;
    logic clk240 = 1'b0;
    always #2 clk240 = ~clk240;

    logic rst, sclk, cs, mosi;
    logic [31:0] rdw_a [4];
    logic [31:0] rdw_b [4];

    spi_reg_slave_if #(.DW(8),  .NREG(4)) bus_a ();
    spi_reg_slave_if #(.DW(32), .NREG(4)) bus_b ();

    assign bus_a.sclk = sclk;
    assign bus_a.cs   = cs;
    assign bus_a.mosi = mosi;
    assign bus_b.sclk = sclk;
    assign bus_b.cs   = cs;
    assign bus_b.mosi = mosi;
    assign bus_a.rd_data = {rdw_a[3][7:0], rdw_a[2][7:0], rdw_a[1][7:0], rdw_a[0][7:0]};
    assign bus_b.rd_data = {rdw_b[3], rdw_b[2], rdw_b[1], rdw_b[0]};

    spi_reg_slave #(.DW(8),  .NREG(4), .BASE_ADR(1))  dut_a (.clk240(clk240), .rst(rst), .bus(bus_a));
    spi_reg_slave #(.DW(32), .NREG(4), .BASE_ADR(32)) dut_b (.clk240(clk240), .rst(rst), .bus(bus_b));

    int          n_vec = 0;
    int          n_bad = 0;
    bit          sent [$];
    int          pos;
    logic [63:0] miso_va, miso_vb;
    logic        busy_end_a, busy_end_b;
    logic [31:0] wrm_a, wrm_b;
    int          rdq_a [$];
    int          rdq_b [$];
    logic [39:0] wrq_a [$];
    logic [39:0] wrq_b [$];

    // Strobe monitor: every asserted cycle is logged, so a stretched pulse shows up as an extra entry.
    always @(negedge clk240) begin
        if (bus_a.rd_stb) rdq_a.push_back(int'(bus_a.rd_idx));
        if (bus_b.rd_stb) rdq_b.push_back(int'(bus_b.rd_idx));
        if (bus_a.wr_stb) wrq_a.push_back({8'(bus_a.wr_idx), 32'(bus_a.wr_data)});
        if (bus_b.wr_stb) wrq_b.push_back({8'(bus_b.wr_idx), 32'(bus_b.wr_data)});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk240);
    endtask

    task automatic start_txn(input logic [7:0] cmd, input logic [63:0] data, input int nbits);
        sent.delete();
        for (int i = 0; i < 8; i++) sent.push_back(cmd[7-i]);
        for (int j = 0; j < nbits; j++) sent.push_back(data[63-j]);
        pos = 0;
        miso_va = '1;
        miso_vb = '1;
        rdq_a.delete(); rdq_b.delete(); wrq_a.delete(); wrq_b.delete();
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(6);
    endtask

    task automatic shift_bits(input int n);
        for (int i = 0; i < n; i++) begin
            mosi = (pos < sent.size()) ? sent[pos] : 1'b0;
            tick(8);
            if (pos >= 8) begin
                miso_va[63-(pos-8)] = bus_a.miso;
                miso_vb[63-(pos-8)] = bus_b.miso;
            end
            sclk = 1'b1;
            tick(8);
            sclk = 1'b0;
            pos++;
        end
    endtask

    task automatic cs_high();
        tick(8);
        busy_end_a = bus_a.busy;
        busy_end_b = bus_b.busy;
        cs = 1'b1;
        tick(8);
    endtask

    // Word-level expectation for one instance: which words stream out, which strobes fire.
    task automatic check_dut(input int d, input logic [7:0] cmd, input int nbits);
        int          dw, base, a, idx, f, nrd, nwr;
        bit          hit, rd;
        logic [63:0] got_miso, exp_miso;
        logic [31:0] w, v;
        int          rq [$];
        logic [39:0] wq [$];
        if (d == 0) begin
            dw = 8;  base = 1;  got_miso = miso_va; rq = rdq_a; wq = wrq_a;
        end else begin
            dw = 32; base = 32; got_miso = miso_vb; rq = rdq_b; wq = wrq_b;
        end
        a   = int'(cmd[6:0]);
        hit = (a >= base) && (a < base + 4);
        rd  = hit && !cmd[7];
        idx = a - base;
        f   = nbits / dw;
        exp_miso = '1;
        if (rd) begin
            for (int j = 0; j < nbits; j++) begin
                w = (d == 0) ? rdw_a[(idx + j / dw) % 4] : rdw_b[(idx + j / dw) % 4];
                exp_miso[63-j] = w[dw - 1 - j % dw];
            end
        end
        check($sformatf("miso%0d", d), got_miso, exp_miso);
        nrd = rd ? f + 1 : 0;
        check($sformatf("rd_cnt%0d", d), 64'(rq.size()), 64'(nrd));
        for (int k = 0; k < nrd; k++)
            if (k < rq.size()) check($sformatf("rd_idx%0d", d), 64'(rq[k]), 64'((idx + k) % 4));
        nwr = (hit && cmd[7]) ? f : 0;
        check($sformatf("wr_cnt%0d", d), 64'(wq.size()), 64'(nwr));
        for (int k = 0; k < nwr; k++) begin
            v = 32'd0;
            for (int b = 0; b < dw; b++) v = {v[30:0], 1'(sent[8 + k * dw + b])};
            if (k < wq.size()) check($sformatf("wr%0d", d), 64'(wq[k]), 64'({8'((idx + k) % 4), v}));
            if (d == 0) wrm_a = v; else wrm_b = v;
        end
        check($sformatf("wr_data%0d", d), (d == 0) ? 64'(bus_a.wr_data) : 64'(bus_b.wr_data),
              (d == 0) ? 64'(wrm_a) : 64'(wrm_b));
        check($sformatf("busy_end%0d", d), 64'((d == 0) ? busy_end_a : busy_end_b), 64'(hit));
        check($sformatf("idle%0d", d), (d == 0) ? 64'({bus_a.busy, bus_a.miso}) : 64'({bus_b.busy, bus_b.miso}),
              64'(2'b01));
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [63:0] data, input int nbits);
        start_txn(cmd, data, nbits);
        cs_low();
        shift_bits(8 + nbits);
        cs_high();
        check_dut(0, cmd, nbits);
        check_dut(1, cmd, nbits);
    endtask

    logic [7:0]  rcmd;
    logic [63:0] rdata;
    int          rbits;

    initial begin
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wrm_a = 32'd0; wrm_b = 32'd0;
        for (int i = 0; i < 4; i++) begin
            rdw_a[i] = $urandom;
            rdw_b[i] = $urandom;
        end
        tick(5);
        rst = 1'b0;
        tick(2);
        check("rst_miso", 64'(bus_a.miso), 64'(1'b1));
        check("rst_stb", 64'({bus_a.rd_stb, bus_a.wr_stb, bus_b.rd_stb, bus_b.wr_stb}), 64'(4'b0000));
        check("rst_idx", 64'({bus_a.rd_idx, bus_a.wr_idx}), 64'(4'h0));
        check("rst_wr_data", 64'({bus_a.wr_data, bus_b.wr_data}), 64'(40'h0));
        check("rst_busy", 64'({bus_a.busy, bus_b.busy}), 64'(2'b00));
        tick(8);

        // Single read of 0xA5 from address 0x02.
        rdw_a[1] = 32'h0000_00A5;
        run_txn(8'h02, 64'h0, 8);
        // Write burst wrapping 3 -> 0 -> 1.
        run_txn(8'h84, 64'h1122_3300_0000_0000, 24);
        // Address outside both windows.
        run_txn(8'h10, 64'hFFFF_0000_0000_0000, 16);
        // A complete write, then a write cut off after 5 bits.
        run_txn(8'h81, 64'h5C00_0000_0000_0000, 8);
        run_txn(8'h81, 64'hA800_0000_0000_0000, 5);
        // Wide read burst across two words.
        rdw_b[0] = 32'h1234_5678;
        rdw_b[1] = 32'hCAFE_F00D;
        run_txn(8'h20, 64'h0, 64);

        // Reset in the middle of the 4th data bit of a read, with cs held low.
        rdw_a[1] = 32'h0000_003C;
        start_txn(8'h02, 64'h0, 24);
        cs_low();
        shift_bits(11);
        check("pre_rst_miso", 64'(miso_va[63:61]), 64'(3'b001));
        check("pre_rst_rd", 64'(rdq_a.size()), 64'(1));
        tick(3);
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        rdq_a.delete(); wrq_a.delete(); rdq_b.delete(); wrq_b.delete();
        miso_va = '1;
        wrm_a = 32'd0; wrm_b = 32'd0;
        shift_bits(13);
        check("post_rst_miso", miso_va, 64'hFFFF_FFFF_FFFF_FFFF);
        check("post_rst_stb", 64'(rdq_a.size() + wrq_a.size() + rdq_b.size() + wrq_b.size()), 64'(0));
        check("post_rst_busy", 64'(bus_a.busy), 64'(1'b0));
        check("post_rst_wr_data", 64'(bus_a.wr_data), 64'(wrm_a));
        cs_high();
        run_txn(8'h01, 64'h0, 16);

        // Random mix of hits on either window and arbitrary commands.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 4; i++) begin
                rdw_a[i] = $urandom;
                rdw_b[i] = $urandom;
            end
            case ($urandom_range(0, 2))
                0:       rcmd = {1'($urandom_range(0, 1)), 7'(1 + $urandom_range(0, 3))};
                1:       rcmd = {1'($urandom_range(0, 1)), 7'(32 + $urandom_range(0, 3))};
                default: rcmd = 8'($urandom);
            endcase
            rdata = {$urandom, $urandom};
            rbits = $urandom_range(0, 64);
            run_txn(rcmd, rdata, rbits);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

Parametrised SPI slave register port running in the clk240 domain. It oversamples an external SPI bus (mode 0, MSB first) and decodes a 1-byte command: an R/W flag plus a 7-bit address. It then serves read or write bursts of DW-bit words across a window of NREG consecutive addresses. Each completed word produces a one-cycle read or write strobe, which can drive FIFO pops and register writes in the surrounding design.

## Interface
- DW, 8, data word width in bits; legal range 8..32.
- NREG, 4, number of consecutive addresses served; legal range 1..16.
- BASE_ADR, 1, first served 7-bit address; BASE_ADR+NREG <= 128.
- AW (local), max(1, clog2(NREG)), index width.

- clk240  in  1  system clock; every flop is clocked on its rising edge.
- rst  in  1  reset: synchronous, active-high.
- sclk  in  1  SPI clock, asynchronous to clk240.
- cs  in  1  SPI chip select, active-low, asynchronous to clk240.
- mosi  in  1  SPI data in, asynchronous to clk240.
- miso  out  1  SPI data out, registered; idles high.
- rd_data  in  NREG*DW  read sources; word i occupies bits [i*DW +: DW].
- rd_stb  out  1  one-cycle pulse: word rd_idx was loaded for shifting out.
- rd_idx  out  AW  index of the word just loaded.
- wr_stb  out  1  one-cycle pulse: wr_data/wr_idx are valid.
- wr_idx  out  AW  index of the written word.
- wr_data  out  DW  received write word.
- busy  out  1  high while the state is ADDR or DATA.

## Operation
- **Synchronisation.** sclk, cs and mosi each pass through a 3-flop synchroniser.
  - Rise, fall and cs-fall/cs-rise events are decoded from synchroniser stages 2/3.
  - mosi is taken from stage 3, so it is aligned with the edge event.
- **Command byte.** bit7 = R/W (0 = read, 1 = write); bits 6:0 = address.
  - A command matches when BASE_ADR <= address < BASE_ADR+NREG.
  - Start index = address − BASE_ADR.
- **IDLE.** miso=1. A cs-fall event moves to ADDR with the bit counter cleared.
- **ADDR.** On each sclk-rise event, shift mosi into the command register and increment the counter.
  - On the 8th rise with a match, go to DATA.
    - Read: load rd_data word[index] into the shift register.
    - Write: clear the shift register.
  - On the 8th rise with no match, go to SKIP.
- **DATA, read.**
  - miso = shift-register MSB.
  - Each sclk-fall event shifts the register left; the vacated LSB is filled with 1.
  - On the DW-th sclk-rise event, increment the index and load the next word.
- **DATA, write.**
  - Each sclk-rise event shifts mosi in.
  - On the DW-th rise, latch wr_data, set wr_idx = index and pulse wr_stb.
  - Then increment the index.
- **Index wrap.** The index increments modulo NREG (NREG−1 → 0), so bursts are unlimited.
- **SKIP.** miso=1; all sclk activity is ignored until cs rises.
- **cs-rise event.** From any state, go to IDLE in the same cycle.
  - A partial word is discarded: no strobe is issued and wr_data is unchanged.
- **Simultaneous events.** cs-rise takes priority over an sclk event in the same cycle.
- **rd_stb timing.** rd_stb pulses with rd_idx on every word load, including the first load at the end of the command.
- **Reset.**
  - State = IDLE; shift, command and counter registers are cleared.
  - Outputs: miso=1, rd_stb=0, wr_stb=0, rd_idx=0, wr_idx=0, wr_data=0, busy=0.
  - Reset mid-transaction produces no strobe.
  - If cs is already low when reset releases, the transaction is ignored until a fresh cs-fall.

## Timing
- Edge-event latency: 3 clk240 cycles from a pin transition.
- **Strobes.**
  - wr_stb is asserted 1 cycle after the DW-th rise event and lasts exactly 1 cycle.
  - rd_stb is asserted 1 cycle after each load and lasts exactly 1 cycle.
  - rd_idx and wr_idx hold their values until the next strobe.
- **miso.**
  - The first data bit is valid 1 cycle after the 8th rise event.
  - Later bits are valid 1 cycle after each fall event.
  - Worst case from pin edge to miso: 5 clk240 cycles.
- **Supported SPI rate.** sclk ≤ clk240/8, i.e. sclk high and low phases each ≥ 4 clk240 cycles.
- **Chip-select timing.** cs setup before the first sclk rise, and hold after the last fall, are each ≥ 4 clk240 cycles.
- **rd_data.** Sampled only in the load cycle and need not be stable otherwise.

## Test plan
- **Single read.**
  - Stimulus: DW=8, BASE_ADR=1; command 0x02, rd_data word1=0xA5.
  - Required: miso shifts out 10100101; one rd_stb with rd_idx=1; wr_stb never asserts.
- **Write burst with wrap.**
  - Stimulus: NREG=4; command 0x84 (write, index 3); data 0x11, 0x22, 0x33.
  - Required: three wr_stb pulses with (idx,data) = (3,0x11), (0,0x22), (1,0x33).
- **Address miss.**
  - Stimulus: command 0x10 (address 16, outside the window); then 16 sclk cycles.
  - Required: miso=1 throughout; no strobes; busy falls after 8 bits (entry to SKIP).
- **Aborted word.**
  - Stimulus: write command 0x81, then cs rises after 5 data bits.
  - Required: no wr_stb; wr_data retains its previous value; state returns to IDLE.
- **Reset mid-read.**
  - Stimulus: assert rst during the 4th data bit while cs stays low, then continue clocking sclk.
  - Required: miso=1; no strobes; a new cs fall followed by command 0x01 reads correctly.
- **Wide word.**
  - Stimulus: DW=32; read burst of 2 words from index 0, rd_data = {0xCAFEF00D, 0x12345678}.
  - Required: miso shifts out 0x12345678 then 0xCAFEF00D, MSB first; rd_stb pulses with rd_idx 0, then 1, then 2 (the pre-load after the last word).
